// File: rtl/xswitch_pkg.sv
// Shared types for the xswitch ingress transmitter: default port widths,
// the buffered packet record and the transmit FSM states.
package xswitch_pkg;

    localparam int DEFAULT_DATA_W = 8;
    localparam int DEFAULT_ADDR_W = 2;

    typedef struct packed {
        logic [DEFAULT_ADDR_W-1:0] addr;
        logic [DEFAULT_DATA_W-1:0] data;
    } pkt_t;

    typedef enum logic [1:0] {
        IDLE,
        SEND,
        DROP
    } tx_state_t;

endpackage

// File: rtl/xswitch_fifo.sv
// Single-clock FIFO of packet records; the head is visible on rd_item
// whenever the FIFO is not empty.
module xswitch_fifo
    import xswitch_pkg::*;
#(
    parameter int  DEPTH  = 4,
    parameter type item_t = pkt_t
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   wr_en,
    input  item_t                  wr_item,
    input  logic                   rd_en,
    output item_t                  rd_item,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] level
);

    localparam int PTR_W = $clog2(DEPTH);

    item_t            mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_wr;
    logic             do_rd;

    assign full    = (level == ($clog2(DEPTH) + 1)'(DEPTH));
    assign empty   = (level == '0);
    assign do_wr   = wr_en && !full;
    assign do_rd   = rd_en && !empty;
    assign rd_item = mem[rd_ptr];

    // Storage carries no reset; only the pointers and level define validity.
    always_ff @(posedge clk) begin
        if (do_wr) begin
            mem[wr_ptr] <= wr_item;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_wr) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_rd) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (do_wr && !do_rd) begin
                level <= level + 1'b1;
            end else if (do_rd && !do_wr) begin
                level <= level - 1'b1;
            end
        end
    end

endmodule

// File: rtl/xswitch_ingress_tx.sv
// xswitch ingress transmitter: buffers host packets and presents them to one
// switch ingress port, dropping any packet stalled for TIMEOUT cycles.
module xswitch_ingress_tx
    import xswitch_pkg::*;
#(
    parameter int DATA_W  = DEFAULT_DATA_W,
    parameter int ADDR_W  = DEFAULT_ADDR_W,
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   push_valid,
    output logic                   push_ready,
    input  logic [ADDR_W-1:0]      push_addr,
    input  logic [DATA_W-1:0]      push_data,
    output logic                   valid_in,
    output logic [ADDR_W-1:0]      addr_in,
    output logic [DATA_W-1:0]      data_in,
    input  logic                   rcv_rdy,
    output logic                   drop_pulse,
    output logic [CNT_W-1:0]       sent_count,
    output logic [CNT_W-1:0]       drop_count,
    output logic [$clog2(DEPTH):0] fifo_level
);

    localparam int STALL_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [STALL_W-1:0] STALL_LAST =
        (TIMEOUT > 0) ? STALL_W'(TIMEOUT - 1) : '0;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } port_pkt_t;

    tx_state_t         state;
    tx_state_t         state_next;
    port_pkt_t         out_pkt;
    port_pkt_t         push_pkt;
    port_pkt_t         fifo_head;
    logic [STALL_W-1:0] stall_cnt;
    logic              fifo_full;
    logic              fifo_empty;
    logic              fifo_wr;
    logic              push_acc;
    logic              pop;
    logic              bypass;
    logic              transfer;
    logic              timeout_hit;

    assign push_pkt    = {push_addr, push_data};
    assign push_ready  = !fifo_full;
    assign push_acc    = push_valid && !fifo_full;
    assign transfer    = (state == SEND) && rcv_rdy;
    assign timeout_hit = (TIMEOUT != 0) && (stall_cnt == STALL_LAST);
    assign fifo_wr     = push_acc && !bypass;

    xswitch_fifo #(
        .DEPTH  (DEPTH),
        .item_t (port_pkt_t)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (fifo_wr),
        .wr_item (push_pkt),
        .rd_en   (pop),
        .rd_item (fifo_head),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .level   (fifo_level)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // A push may skip the FIFO only when the output register is being
    // vacated and nothing older is waiting; a DROP cycle never bypasses.
    always_comb begin
        state_next = state;
        pop        = 1'b0;
        bypass     = 1'b0;
        unique case (state)
            IDLE: begin
                if (!fifo_empty) begin
                    pop        = 1'b1;
                    state_next = SEND;
                end else if (push_acc) begin
                    bypass     = 1'b1;
                    state_next = SEND;
                end
            end
            SEND: begin
                if (rcv_rdy) begin
                    if (!fifo_empty) begin
                        pop = 1'b1;
                    end else if (push_acc) begin
                        bypass = 1'b1;
                    end else begin
                        state_next = IDLE;
                    end
                end else if (timeout_hit) begin
                    state_next = DROP;
                end
            end
            DROP: begin
                if (!fifo_empty) begin
                    pop        = 1'b1;
                    state_next = SEND;
                end else begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        valid_in   = (state == SEND);
        drop_pulse = (state == DROP);
        addr_in    = out_pkt.addr;
        data_in    = out_pkt.data;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out_pkt    <= '0;
            stall_cnt  <= '0;
            sent_count <= '0;
            drop_count <= '0;
        end else begin
            if (pop) begin
                out_pkt <= fifo_head;
            end else if (bypass) begin
                out_pkt <= push_pkt;
            end else if (state_next != SEND) begin
                out_pkt <= '0;
            end
            if ((state == SEND) && !rcv_rdy && !timeout_hit) begin
                stall_cnt <= stall_cnt + 1'b1;
            end else begin
                stall_cnt <= '0;
            end
            if (transfer) begin
                sent_count <= sent_count + 1'b1;
            end
            if (state == DROP) begin
                drop_count <= drop_count + 1'b1;
            end
        end
    end

endmodule

// File: doc/xswitch_ingress_tx.md
Name: xswitch_ingress_tx

Overview:
- Transmitter that drives one ingress port of the xswitch (data_in/addr_in/valid_in, back-pressured by rcv_rdy).
- Buffers (addr, data) packets from a local host push interface in a small FIFO.
- Presents packets to the switch one at a time with a valid/ready handshake.
- Drops a packet the switch has stalled for too long, and counts sent and dropped packets.

Parameters:
- DATA_W, 8, packet data width; must match the switch data_in.
- ADDR_W, 2, destination port address width; must match the switch addr_in.
- DEPTH, 4, FIFO entries; power of two, at least 2.
- TIMEOUT, 16, consecutive stalled cycles before a drop; 0 disables dropping.
- CNT_W, 16, width of the statistics counters.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- push_valid  in  1  host offers a packet.
- push_ready  out  1  FIFO can accept (not full).
- push_addr  in  ADDR_W  destination port of the offered packet.
- push_data  in  DATA_W  payload of the offered packet.
- valid_in  out  1  packet presented to the switch.
- addr_in  out  ADDR_W  destination address to the switch.
- data_in  out  DATA_W  payload to the switch.
- rcv_rdy  in  1  switch accepts the presented packet this cycle.
- drop_pulse  out  1  one-cycle pulse when a packet is dropped on timeout.
- sent_count  out  CNT_W  packets accepted by the switch.
- drop_count  out  CNT_W  packets dropped.
- fifo_level  out  $clog2(DEPTH)+1  FIFO occupancy; excludes the output register.

Behaviour:
- Reset (reset=0, asynchronous) forces:
  - valid_in=0, addr_in=0, data_in=0, drop_pulse=0;
  - sent_count=0, drop_count=0, fifo_level=0;
  - FIFO empty, output register empty, stall counter 0, FSM IDLE.
- Reset asserted mid-handshake discards all buffered packets; the packet held on valid_in is lost and not counted.
- Push accept: a packet enters on a rising edge where push_valid && push_ready.
  - push_ready = !fifo_full.
  - No pass-through when full: push is refused even if a pop happens that cycle.
- Output register: valid_in/addr_in/data_in are registered outputs. Total capacity is DEPTH+1 packets.
- Transfer: occurs on a rising edge where valid_in && rcv_rdy.
  - addr_in and data_in are held stable while valid_in=1 and no transfer has occurred.
  - valid_in never deasserts without a transfer, except on drop or reset.
- FSM IDLE (valid_in=0):
  - FIFO non-empty: load head into the output register and go to SEND.
  - FIFO empty with a push this cycle: the push bypasses the FIFO into the output register; SEND next cycle.
  - Latency from push accept to valid_in=1 is 1 cycle.
- FSM SEND (valid_in=1):
  - On transfer: sent_count += 1 and stall counter cleared.
    - FIFO non-empty: load the next head on the same edge and stay in SEND (back-to-back, no bubble).
    - FIFO empty: go to IDLE. If a push arrives in the same cycle, it bypasses to the output register and the FSM stays in SEND.
  - No transfer: stall counter += 1.
    - When the counter reaches TIMEOUT (TIMEOUT≠0), go to DROP on that edge, with valid_in=0 and the output register cleared.
- FSM DROP (one cycle):
  - drop_pulse=1 and drop_count += 1; stall counter cleared; valid_in=0.
  - Next state: SEND with the next FIFO head if non-empty, else IDLE. No bypass in DROP.
- Counters wrap modulo 2^CNT_W; no saturation.
- Simultaneous push and pop: occupancy is unchanged; both take effect.
- rcv_rdy while valid_in=0 is ignored.

Decomposition:
- Package xswitch_pkg holds:
  - DATA_W and ADDR_W defaults;
  - typedef struct packed pkt_t {addr, data};
  - typedef enum tx_state_t {IDLE, SEND, DROP}.
- Sub-module xswitch_fifo: synchronous single-clock FIFO of pkt_t with DEPTH entries.
  - Signals: full, empty, level.
  - Same asynchronous active-low reset.
- The FSM, output register, stall counter and statistics counters live in xswitch_ingress_tx.

Test Plan:
- Single packet: push addr=2, data=0xA5 with rcv_rdy=1 → valid_in=1 one cycle after accept with addr_in=2, data_in=0xA5; transfer on that edge; sent_count=1; valid_in=0 afterwards.
- Back-to-back: push 5 packets (0x01..0x05) with rcv_rdy=1 → valid_in high 5 consecutive cycles carrying data 0x01..0x05 in order; sent_count=5.
- Back-pressure: rcv_rdy=0 for 10 cycles, then 1 → addr_in/data_in stable for all 10 cycles; exactly one transfer; no drop (TIMEOUT=16).
- Full FIFO: hold rcv_rdy=0 and push 6 packets → push_ready=0 after 5 accepts (1 in the output register + 4 in the FIFO); fifo_level=4; sixth packet refused.
- Timeout: rcv_rdy=0 permanently with 2 packets queued → valid_in drops after 16 stalled cycles; drop_pulse for 1 cycle; drop_count=1; second packet presented on the following cycle.
- Reset mid-operation: reset=0 while valid_in=1 with 3 packets queued → valid_in=0 and fifo_level=0 immediately (asynchronous); counters 0; after release, no packet is presented until a new push.
